// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID->EX boundary.
// ALU-op classes, opcodes and the per-entry bundle.
package id_ex_stage_pkg;

   localparam int IDEX_XLEN = 32;

   localparam logic [1:0] ALUOP_R  = 2'b10;
   localparam logic [1:0] ALUOP_I  = 2'b11;
   localparam logic [1:0] ALUOP_U  = 2'b01;
   localparam logic [1:0] ALUOP_SL = 2'b00;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [1:0] aluop;
      logic [3:0] ins_30_14_12;
      logic       src_a_pc;
      logic       src_b_imm;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       illegal;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [6:0] opcode;
   } idex_ctrl_t;

   typedef struct packed {
      logic [IDEX_XLEN-1:0] pc;
      logic [IDEX_XLEN-1:0] rs1_data;
      logic [IDEX_XLEN-1:0] rs2_data;
      logic [IDEX_XLEN-1:0] imm;
      idex_ctrl_t           ctrl;
   } idex_entry_t;

   // ALUOP_SL is all-zero, so a zeroed entry is the reset entry
   localparam idex_entry_t IDEX_RESET = '0;

endpackage

// File: rtl/idex_decode.sv
// Combinational instruction decode into EX control fields.
// Used on the ID side so the buffer stores decoded controls.
module idex_decode
   import id_ex_stage_pkg::*;
(
   input  logic [31:0] inst,
   output idex_ctrl_t  ctrl
);

   logic [6:0] op;
   logic       unused_bits;

   assign op          = inst[6:0];
   assign unused_bits = ^{inst[31], inst[29:25]};

   always_comb begin
      ctrl              = '0;
      ctrl.aluop        = ALUOP_SL;
      ctrl.ins_30_14_12 = {inst[30], inst[14:12]};
      ctrl.rs1          = inst[19:15];
      ctrl.rs2          = inst[24:20];
      ctrl.rd           = inst[11:7];
      ctrl.opcode       = op;
      unique case (1'b1)
         (op == OP_R): begin
            ctrl.aluop  = ALUOP_R;
            ctrl.reg_wr = 1'b1;
         end
         (op == OP_I): begin
            ctrl.aluop     = ALUOP_I;
            ctrl.src_b_imm = 1'b1;
            ctrl.reg_wr    = 1'b1;
         end
         (op == OP_LOAD): begin
            ctrl.src_b_imm = 1'b1;
            ctrl.mem_rd    = 1'b1;
            ctrl.reg_wr    = 1'b1;
         end
         (op == OP_STORE): begin
            ctrl.src_b_imm = 1'b1;
            ctrl.mem_wr    = 1'b1;
         end
         (op == OP_LUI): begin
            ctrl.aluop     = ALUOP_U;
            ctrl.src_b_imm = 1'b1;
            ctrl.reg_wr    = 1'b1;
         end
         (op == OP_AUIPC): begin
            ctrl.src_a_pc  = 1'b1;
            ctrl.src_b_imm = 1'b1;
            ctrl.reg_wr    = 1'b1;
         end
         (op == OP_JAL), (op == OP_JALR): begin
            ctrl.reg_wr = 1'b1;
         end
         (op == OP_BRANCH): begin
            ctrl.reg_wr = 1'b0;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
      if (ctrl.rd == 5'd0) ctrl.reg_wr = 1'b0;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with a 2-entry skid buffer.
// id_ready depends only on local state, never on ex_ready.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = IDEX_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [31:0]     id_inst,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [1:0]      ex_aluop,
   output logic [3:0]      ex_ins_30_14_12,
   output logic            ex_src_a_pc,
   output logic            ex_src_b_imm,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_reg_wr,
   output logic            ex_illegal
);

   idex_ctrl_t  dec;
   idex_entry_t in_e;
   idex_entry_t main_q;
   idex_entry_t skid_q;
   logic        main_valid;
   logic        skid_valid;
   logic        accept;
   logic        ex_xfer;

   idex_decode u_decode (
      .inst (id_inst),
      .ctrl (dec)
   );

   always_comb begin
      in_e          = IDEX_RESET;
      in_e.pc       = id_pc;
      in_e.rs1_data = id_rs1_data;
      in_e.rs2_data = id_rs2_data;
      in_e.imm      = id_imm;
      in_e.ctrl     = dec;
   end

   assign id_ready = rst_n & ~skid_valid;
   assign accept   = id_valid & id_ready;
   assign ex_xfer  = main_valid & ex_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= IDEX_RESET;
         skid_q     <= IDEX_RESET;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid) begin
         if (accept) begin
            main_q     <= in_e;
            main_valid <= 1'b1;
         end
      end else if (!skid_valid) begin
         if (ex_xfer && accept) begin
            main_q <= in_e;
         end else if (ex_xfer) begin
            main_valid <= 1'b0;
         end else if (accept) begin
            skid_q     <= in_e;
            skid_valid <= 1'b1;
         end
      end else if (ex_xfer) begin
         main_q     <= skid_q;
         skid_valid <= 1'b0;
      end
   end

   assign ex_valid        = main_valid;
   assign ex_pc           = main_q.pc;
   assign ex_rs1_data     = main_q.rs1_data;
   assign ex_rs2_data     = main_q.rs2_data;
   assign ex_imm          = main_q.imm;
   assign ex_rs1          = main_q.ctrl.rs1;
   assign ex_rs2          = main_q.ctrl.rs2;
   assign ex_rd           = main_q.ctrl.rd;
   assign ex_opcode       = main_q.ctrl.opcode;
   assign ex_aluop        = main_q.ctrl.aluop;
   assign ex_ins_30_14_12 = main_q.ctrl.ins_30_14_12;
   assign ex_src_a_pc     = main_q.ctrl.src_a_pc;
   assign ex_src_b_imm    = main_q.ctrl.src_b_imm;
   // stale entries left behind by a flush must not look like writes
   assign ex_mem_rd       = main_valid & main_q.ctrl.mem_rd;
   assign ex_mem_wr       = main_valid & main_q.ctrl.mem_wr;
   assign ex_reg_wr       = main_valid & main_q.ctrl.reg_wr;
   assign ex_illegal      = main_valid & main_q.ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: ID stimulus is queued,
// every EX transfer is popped and compared field by field.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_pc = '0;
   logic [31:0] id_inst = '0;
   logic [31:0] id_rs1_data = '0;
   logic [31:0] id_rs2_data = '0;
   logic [31:0] id_imm = '0;
   logic        flush = 1'b0;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [6:0]  ex_opcode;
   logic [1:0]  ex_aluop;
   logic [3:0]  ex_ins_30_14_12;
   logic        ex_src_a_pc, ex_src_b_imm;
   logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_illegal;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] pc, inst, a, b, imm;
   } item_t;
   item_t sb[$];

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_inst(id_inst),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_opcode(ex_opcode), .ex_aluop(ex_aluop),
      .ex_ins_30_14_12(ex_ins_30_14_12),
      .ex_src_a_pc(ex_src_a_pc), .ex_src_b_imm(ex_src_b_imm),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_reg_wr(ex_reg_wr), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {aluop[1:0], src_a_pc, src_b_imm, mem_rd, mem_wr, reg_wr, illegal}
   function automatic logic [7:0] model(input logic [31:0] inst);
      logic [7:0] r;
      case (inst[6:0])
         7'h33:        r = {2'b10, 6'b000010};
         7'h13:        r = {2'b11, 6'b010010};
         7'h03:        r = {2'b00, 6'b011010};
         7'h23:        r = {2'b00, 6'b010100};
         7'h37:        r = {2'b01, 6'b010010};
         7'h17:        r = {2'b00, 6'b110010};
         7'h6F, 7'h67: r = {2'b00, 6'b000010};
         7'h63:        r = {2'b00, 6'b000000};
         default:      r = {2'b00, 6'b000001};
      endcase
      if (inst[11:7] == 5'd0) r[1] = 1'b0;
      return r;
   endfunction

   item_t        e;
   logic [7:0]   m;
   logic [161:0] exp_v, act_v;

   always @(negedge clk) begin
      if (ex_valid && ex_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL ex_unexpected pc=%h opcode=%h, required no transfer",
                     ex_pc, ex_opcode);
         end else begin
            e = sb.pop_front();
            m = model(e.inst);
            exp_v = {e.pc, e.a, e.b, e.imm, e.inst[19:15], e.inst[24:20],
                     e.inst[11:7], e.inst[6:0], m[7:6], e.inst[30],
                     e.inst[14:12], m[5:0]};
            act_v = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                     ex_rd, ex_opcode, ex_aluop, ex_ins_30_14_12, ex_src_a_pc,
                     ex_src_b_imm, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_illegal};
            if (act_v !== exp_v) begin
               n_err++;
               $display("FAIL ex_entry got %h want %h", act_v, exp_v);
            end
         end
      end
      if (!rst_n || flush) sb.delete();
      else if (id_valid && id_ready)
         sb.push_back('{id_pc, id_inst, id_rs1_data, id_rs2_data, id_imm});
   end

   task automatic set_id(input logic [31:0] inst, input logic [31:0] pc);
      id_valid    = 1'b1;
      id_inst     = inst;
      id_pc       = pc;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
   endtask

   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      bit ok = 1'b0;
      set_id(inst, pc);
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = id_ready;
         @(posedge clk);
         #1;
      end
      id_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout pc=%h got no id_ready, required accept", pc);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_cmp++;
      if ({sb.size() == 0, ex_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL drain left=%0d ex_valid=%b, required 0 and 0",
                  sb.size(), ex_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({id_ready, ex_valid, ex_aluop, ex_pc, ex_reg_wr, ex_imm} !== '0) begin
         n_err++;
         $display("FAIL reset_state rdy=%b v=%b op=%b pc=%h, required all 0",
                  id_ready, ex_valid, ex_aluop, ex_pc);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (id_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release id_ready=%b, required 1", id_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_srai();
      ex_ready = 1'b1;
      send(32'h002081B3, 32'h100);
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_aluop, ex_ins_30_14_12, ex_rd, ex_reg_wr, ex_src_b_imm}
          !== {1'b1, 2'b10, 4'b0000, 5'd3, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL add v=%b op=%b sel=%b rd=%0d wr=%b b=%b, required 1 10 0000 3 1 0",
                  ex_valid, ex_aluop, ex_ins_30_14_12, ex_rd, ex_reg_wr, ex_src_b_imm);
      end
      @(posedge clk);
      #1;
      send(32'h4032D293, 32'h104);
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_aluop, ex_ins_30_14_12, ex_src_b_imm}
          !== {1'b1, 2'b11, 4'b1101, 1'b1}) begin
         n_err++;
         $display("FAIL srai v=%b op=%b sel=%b b=%b, required 1 11 1101 1",
                  ex_valid, ex_aluop, ex_ins_30_14_12, ex_src_b_imm);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_misc_decode();
      ex_ready = 1'b1;
      send(32'h00000397, 32'h200);
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_src_a_pc, ex_aluop, ex_reg_wr, ex_rd}
          !== {1'b1, 1'b1, 2'b00, 1'b1, 5'd7}) begin
         n_err++;
         $display("FAIL auipc v=%b a=%b op=%b wr=%b rd=%0d, required 1 1 00 1 7",
                  ex_valid, ex_src_a_pc, ex_aluop, ex_reg_wr, ex_rd);
      end
      @(posedge clk);
      #1;
      send(32'h00000013, 32'h204);
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_reg_wr} !== 2'b10) begin
         n_err++;
         $display("FAIL addi_x0 v=%b wr=%b, required 1 0", ex_valid, ex_reg_wr);
      end
      @(posedge clk);
      #1;
      send(32'h00000F7F, 32'h208);
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_illegal, ex_mem_rd, ex_mem_wr, ex_reg_wr} !== 5'b11000) begin
         n_err++;
         $display("FAIL illegal v=%b ill=%b rd=%b wr=%b rw=%b, required 1 1 0 0 0",
                  ex_valid, ex_illegal, ex_mem_rd, ex_mem_wr, ex_reg_wr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      ex_ready = 1'b0;
      send(32'h002081B3, 32'h300);
      send(32'h00308213, 32'h304);
      set_id(32'h0000A283, 32'h308);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({id_ready, ex_valid, ex_pc} !== {1'b0, 1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL stall_hold rdy=%b v=%b pc=%h, required 0 1 00000300",
                     id_ready, ex_valid, ex_pc);
         end
         @(posedge clk);
         #1;
      end
      ex_ready = 1'b1;
      send(32'h0000A283, 32'h308);
      send(32'h0020A223, 32'h30C);
      drain();
   endtask

   task automatic test_flush();
      ex_ready = 1'b0;
      send(32'h002081B3, 32'h400);
      send(32'h00308213, 32'h404);
      set_id(32'h123454B7, 32'h408);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      id_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, id_ready} !== 5'b00001) begin
         n_err++;
         $display("FAIL flush v=%b rw=%b rdy=%b, required 0 0 1",
                  ex_valid, ex_reg_wr, id_ready);
      end
      @(posedge clk);
      #1;
      ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_gone ex_valid=%b pc=%h, required 0", ex_valid, ex_pc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [8] = '{
         32'h0000A203, 32'h0020A223, 32'h123454B7, 32'h008000EF,
         32'h000280E7, 32'h00208463, 32'h0020E333, 32'h40208333};
      int c0;
      ex_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(prog[i], 32'h500 + 32'(i * 4));
      n_cmp++;
      if (cyc - c0 !== 8) begin
         n_err++;
         $display("FAIL throughput cycles=%0d, required 8", cyc - c0);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      ex_ready = 1'b0;
      send(32'h002081B3, 32'h600);
      send(32'h00308213, 32'h604);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (id_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_ready id_ready=%b, required 0", id_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ex_valid, ex_pc, ex_rs1_data, ex_imm, ex_aluop, ex_reg_wr, ex_rd, id_ready}
          !== {1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1}) begin
         n_err++;
         $display("FAIL rst_mid v=%b pc=%h a=%h op=%b rd=%0d rdy=%b, required 0 0 0 00 0 1",
                  ex_valid, ex_pc, ex_rs1_data, ex_aluop, ex_rd, id_ready);
      end
      @(posedge clk);
      #1;
      ex_ready = 1'b1;
      send(32'h00000397, 32'h700);
      drain();
   endtask

   initial begin
      test_reset();
      test_add_srai();
      test_misc_decode();
      test_stall();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID→EX pipeline boundary of the core. Accepts one decoded instruction per cycle from ID and registers it, with operands and PC.
- Generates the 2-bit ALU-op class and the {inst[30],inst[14:12]} selector consumed by EX ALU control, plus operand-select and memory/writeback controls.
- Uses a 2-entry skid buffer, so EX back-pressure (e.g. AXI data-bus wait) never forms a combinational ready path back into ID.
- Supports a branch flush.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_pc  in  XLEN  instruction PC
- id_inst  in  32  raw instruction
- id_rs1_data  in  XLEN  rs1 operand
- id_rs2_data  in  XLEN  rs2 operand
- id_imm  in  XLEN  sign-extended immediate
- flush  in  1  kill all held and incoming instructions
- ex_valid  out  1  EX-side entry valid
- ex_ready  in  1  EX consumes entry
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  register indices
- ex_opcode  out  7  inst[6:0], for branch unit
- ex_aluop  out  2  ALUOP_R/I/U/SL
- ex_ins_30_14_12  out  4  {inst[30],inst[14:12]}
- ex_src_a_pc  out  1  1 = ALU A is PC, 0 = rs1
- ex_src_b_imm  out  1  1 = ALU B is imm, 0 = rs2
- ex_mem_rd, ex_mem_wr, ex_reg_wr  out  1  load / store / writeback enables
- ex_illegal  out  1  unrecognised opcode

Behaviour:
- Two entries:
  - main: drives the ex_* outputs.
  - skid: catches a transfer accepted while main stalled.
- id_ready = rst_n & ~skid_valid. It is registered state only and never depends on ex_ready.
- ID transfer occurs when id_valid & id_ready. EX transfer occurs when ex_valid & ex_ready.
- States and transitions:
  - EMPTY (no valid entries): an accept loads main → ONE.
  - ONE (main valid):
    - EX transfer with no accept → EMPTY.
    - EX transfer with accept → main replaced, stay ONE.
    - Accept with no EX transfer → skid loaded → TWO.
  - TWO (both valid): id_ready=0.
    - EX transfer: skid moves to main → ONE.
- Latency: accepted instruction appears on ex_* on the next cycle when main is empty or draining. Throughput is 1/cycle.
- Flush has priority over everything. On the next edge both valid bits clear and the same-cycle ID instruction is dropped. id_ready is 1 the following cycle.
- Reset (rst_n=0 at edge):
  - ex_valid=0, skid_valid=0, all ex_* data/control = 0, ex_aluop = ALUOP_SL.
  - id_ready=0 while rst_n is low.
- Decode is done on entry into the buffer and stored alongside data.
  - R-type 0110011: aluop R, src_b rs2, reg_wr.
  - I-ALU 0010011: aluop I, src_b imm, reg_wr.
  - Load 0000011: aluop SL, src_b imm, mem_rd, reg_wr.
  - Store 0100011: aluop SL, src_b imm, mem_wr.
  - LUI 0110111: aluop U, src_b imm, reg_wr.
  - AUIPC 0010111: aluop SL, src_a pc, src_b imm, reg_wr.
  - JAL 1101111 / JALR 1100111: aluop SL, reg_wr.
  - Branch 1100011: aluop SL, no writes.
  - Any other opcode: ex_illegal=1, all enables 0.
- rd==0 forces ex_reg_wr=0.
- ex_ins_30_14_12 is always {inst[30],inst[14:12]} regardless of type.
- Invalid entries (ex_valid=0) present ex_mem_rd, ex_mem_wr and ex_reg_wr as 0.
- ex_* outputs are held stable while ex_valid & ~ex_ready.

Decomposition:
- Shared package holds:
  - ALUOP_R=2'b10, ALUOP_I=2'b11, ALUOP_U=2'b01, ALUOP_SL=2'b00.
  - Opcode constants.
  - A packed struct idex_entry_t covering all per-entry fields.
- One sub-module, idex_decode: purely combinational, maps inst to control fields. Instantiated once on the ID side.

Test Plan:
- add x3,x1,x2 (0x002081B3) with ex_ready=1 → next cycle: ex_valid=1, ex_aluop=2'b10, ex_ins_30_14_12=4'b0000, ex_rd=3, ex_reg_wr=1, src_b_imm=0.
- srai x5,x5,3 (0x4032D293) → ex_aluop=2'b11, ex_ins_30_14_12=4'b1101, src_b_imm=1.
- Stream of 4 instructions with ex_ready=0 from cycle 1:
  - 1st held in main, 2nd in skid, id_ready=0 thereafter.
  - Raise ex_ready: outputs drain in order 1,2,3,4 with no loss or duplicate.
- flush in TWO state while id_valid=1 → next cycle ex_valid=0 and id_ready=1; none of the three instructions ever appears.
- AUIPC x7 (0x00000397) → src_a_pc=1, aluop SL. Also addi x0,x0,0 → ex_reg_wr=0. Also opcode 0x7F → ex_illegal=1 with all enables 0.
- rst_n low mid-stream for 1 cycle → ex_valid=0, ex_* zero, id_ready=0 during reset, 1 on first cycle after release.
